// File: rtl/fp_cond_compare_pkg.sv
// Shared types and constants for the floating-point condition compare path.
// Predicate encoding, cond bit positions and format geometry helpers.
package fp_cond_compare_pkg;

  typedef enum logic [3:0] {
    FP_F    = 4'd0,
    FP_UN   = 4'd1,
    FP_EQ   = 4'd2,
    FP_UEQ  = 4'd3,
    FP_OLT  = 4'd4,
    FP_ULT  = 4'd5,
    FP_OLE  = 4'd6,
    FP_ULE  = 4'd7,
    FP_SF   = 4'd8,
    FP_NGLE = 4'd9,
    FP_SEQ  = 4'd10,
    FP_NGL  = 4'd11,
    FP_LT   = 4'd12,
    FP_NGE  = 4'd13,
    FP_LE   = 4'd14,
    FP_NGT  = 4'd15
  } fp_cond_t;

  localparam int COND_U = 0;
  localparam int COND_E = 1;
  localparam int COND_L = 2;
  localparam int COND_S = 3;

  localparam int FCC_W = 3;

  // Exponent width for the two supported operand widths.
  function automatic int exp_width(input int w);
    return (w == 64) ? 11 : 8;
  endfunction

endpackage

// File: rtl/fp_cmp_pipe.sv
// Valid/payload shift register of depth D with global hold and flush.
// The last stage drives the outputs directly.
module fp_cmp_pipe #(
  parameter int D  = 4,
  parameter int PW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic [D-1:0]  stage_valid;
  logic [PW-1:0] stage_data [D];
  logic          advance;

  // Holding is global: a stalled output freezes every stage, bubbles included.
  assign advance  = ~stage_valid[D-1] | out_ready;
  assign in_ready = advance;

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_stage
      logic          valid_reg;
      logic [PW-1:0] data_reg;
      logic          valid_next;
      logic [PW-1:0] data_next;

      if (gi == 0) begin : g_head
        assign valid_next = in_valid;
        assign data_next  = in_data;
      end else begin : g_body
        assign valid_next = stage_valid[gi-1];
        assign data_next  = stage_data[gi-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          if (flush) begin
            valid_reg <= 1'b0;
          end else if (advance) begin
            valid_reg <= valid_next;
          end
          if (advance) begin
            data_reg <= data_next;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_data[gi]  = data_reg;
    end
  endgenerate

  assign out_valid = stage_valid[D-1];
  assign out_data  = stage_data[D-1];

endmodule

// File: rtl/fp_cond_compare.sv
// Pipelined c.cond.fmt compare: predicate and invalid flag are resolved in stage 0,
// later stages only carry the result with its FCC index and ROB tag.
module fp_cond_compare
  import fp_cond_compare_pkg::*;
#(
  parameter int W       = 32,
  parameter int D       = 4,
  parameter int TAG_W   = 6,
  parameter int NAN2008 = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [3:0]       cond,
  input  logic [FCC_W-1:0] fcc_idx,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic             invalid,
  output logic [FCC_W-1:0] out_fcc_idx,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_sticky,
  output logic             sticky_invalid
);

  localparam int E  = exp_width(W);
  localparam int F  = W - 1 - E;
  localparam int PW = 2 + FCC_W + TAG_W;

  logic [1:0][W-1:0] opnd;
  logic [1:0][W-2:0] mag;
  logic [1:0]        is_nan;
  logic [1:0]        is_snan;
  logic [1:0]        is_zero;
  logic [1:0]        is_neg;

  assign opnd[0] = a;
  assign opnd[1] = b;

  // Special-case decode for each operand; index 0 is a, index 1 is b.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      logic [E-1:0] exp_f;
      logic [F-1:0] frac_f;

      assign exp_f       = opnd[gi][W-2 -: E];
      assign frac_f      = opnd[gi][F-1:0];
      assign mag[gi]     = opnd[gi][W-2:0];
      assign is_neg[gi]  = opnd[gi][W-1];
      assign is_zero[gi] = ~|mag[gi];
      assign is_nan[gi]  = (&exp_f) & (|frac_f);
      // Legacy encoding signals on fraction MSB set; 2008 signals on it clear.
      assign is_snan[gi] = is_nan[gi] & (frac_f[F-1] ^ (NAN2008 != 0));
    end
  endgenerate

  logic un;
  logic eq;
  logic lt;
  logic ord_lt;
  logic res_y;
  logic res_invalid;

  assign un = |is_nan;
  assign eq = ~un & ((a == b) | (&is_zero));

  always_comb begin
    ord_lt = 1'b0;
    case (is_neg)
      2'b01:   ord_lt = 1'b1;               // a negative, b positive
      2'b10:   ord_lt = 1'b0;               // a positive, b negative
      2'b00:   ord_lt = mag[0] < mag[1];
      default: ord_lt = mag[0] > mag[1];
    endcase
  end

  // eq masks the -0/+0 case that the sign path would otherwise call less-than.
  assign lt = ~un & ~eq & ord_lt;

  assign res_y = (cond[COND_U] & un) | (cond[COND_E] & eq) | (cond[COND_L] & lt);
  assign res_invalid = un & (cond[COND_S] | (|is_snan));

  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_out;

  assign pipe_in = {res_y, res_invalid, fcc_idx, tag};

  fp_cmp_pipe #(
    .D  (D),
    .PW (PW)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (pipe_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pipe_out)
  );

  assign {y, invalid, out_fcc_idx, out_tag} = pipe_out;

  logic sticky_reg;

  // A retiring invalid wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_reg <= 1'b0;
    end else if (out_valid & out_ready & invalid) begin
      sticky_reg <= 1'b1;
    end else if (clr_sticky) begin
      sticky_reg <= 1'b0;
    end
  end

  assign sticky_invalid = sticky_reg;

endmodule

// File: tb/tb_fp_cond_compare.sv
// Scoreboard bench for fp_cond_compare: single-precision D=4 and double-precision D=2.
module tb_fp_cond_compare;
  import fp_cond_compare_pkg::*;

  localparam int TAG_W = 6;
  localparam int DS    = 4;
  localparam int DD    = 2;

  typedef struct packed {
    logic             y;
    logic             inv;
    logic [2:0]       fcc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic clr_sticky = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic             y, invalid, sticky_invalid;
  logic [31:0]      a = '0, b = '0;
  logic [3:0]       cond = '0;
  logic [2:0]       fcc_idx = '0, out_fcc_idx;
  logic [TAG_W-1:0] tag = '0, out_tag;

  logic             in_valid_d = 1'b0, in_ready_d, out_valid_d, out_ready_d = 1'b1;
  logic             y_d, invalid_d, sticky_invalid_d;
  logic [63:0]      a_d = '0, b_d = '0;
  logic [3:0]       cond_d = '0;
  logic [2:0]       fcc_idx_d = '0, out_fcc_idx_d;
  logic [TAG_W-1:0] tag_d = '0, out_tag_d;

  fp_cond_compare #(.W(32), .D(DS), .TAG_W(TAG_W), .NAN2008(0)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cond(cond), .fcc_idx(fcc_idx), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .invalid(invalid),
    .out_fcc_idx(out_fcc_idx), .out_tag(out_tag),
    .clr_sticky(clr_sticky), .sticky_invalid(sticky_invalid)
  );

  fp_cond_compare #(.W(64), .D(DD), .TAG_W(TAG_W), .NAN2008(0)) dut_d (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .a(a_d), .b(b_d), .cond(cond_d), .fcc_idx(fcc_idx_d), .tag(tag_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .y(y_d), .invalid(invalid_d),
    .out_fcc_idx(out_fcc_idx_d), .out_tag(out_tag_d),
    .clr_sticky(clr_sticky), .sticky_invalid(sticky_invalid_d)
  );

  exp_t q_s[$];
  exp_t q_d[$];
  exp_t e_s, e_d;
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Single-precision vectors: a, b, cond, expected y, expected invalid.
  localparam int NV = 14;
  localparam logic [31:0] VA [NV] = '{32'h3f800000, 32'h40000000, 32'h80000000, 32'h80000000,
                                      32'hc0000000, 32'h7fbfffff, 32'h7fbfffff, 32'h7fbfffff,
                                      32'h7fc00000, 32'hff800000, 32'h3f800000, 32'h00000000,
                                      32'h7f800000, 32'h3f800000};
  localparam logic [31:0] VB [NV] = '{32'h40000000, 32'h3f800000, 32'h00000000, 32'h00000000,
                                      32'hbf800000, 32'h3f800000, 32'h3f800000, 32'h3f800000,
                                      32'h3f800000, 32'h00000001, 32'h3f800000, 32'h80000001,
                                      32'h7f800000, 32'h7fc00001};
  localparam logic [3:0]  VC [NV] = '{4'd4, 4'd4, 4'd2, 4'd4, 4'd4, 4'd5, 4'd4, 4'd12,
                                      4'd1, 4'd14, 4'd15, 4'd4, 4'd2, 4'd0};
  localparam logic        VY [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                      1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic        VI [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q_s.size() == 0) begin
        check("sp unexpected result", 64'd1, 64'd0);
      end else begin
        e_s = q_s.pop_front();
        $display("sp result tag=%0d y=%0b invalid=%0b fcc=%0d", out_tag, y, invalid, out_fcc_idx);
        check("sp result {y,inv,fcc,tag}", {53'd0, y, invalid, out_fcc_idx, out_tag}, {53'd0, e_s});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_d && out_ready_d) begin
      if (q_d.size() == 0) begin
        check("dp unexpected result", 64'd1, 64'd0);
      end else begin
        e_d = q_d.pop_front();
        $display("dp result tag=%0d y=%0b invalid=%0b fcc=%0d", out_tag_d, y_d, invalid_d, out_fcc_idx_d);
        check("dp result {y,inv,fcc,tag}", {53'd0, y_d, invalid_d, out_fcc_idx_d, out_tag_d}, {53'd0, e_d});
      end
    end
  end

  // Present one op; the expectation is queued on the cycle it is accepted.
  task automatic issue_s(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] cv,
                         input logic [TAG_W-1:0] tg, input logic ey, input logic ei, input bit push);
    int   n;
    bit   done;
    exp_t e;
    n = 0;
    done = 0;
    a = av; b = bv; cond = cv; tag = tg; fcc_idx = tg[2:0]; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          e.y = ey; e.inv = ei; e.fcc = tg[2:0]; e.tag = tg;
          q_s.push_back(e);
        end
        done = 1;
      end else begin
        n++;
        if (n > 50) begin
          check("sp in_ready timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_d(input logic [63:0] av, input logic [63:0] bv, input logic [3:0] cv,
                         input logic [TAG_W-1:0] tg, input logic ey, input logic ei);
    int   n;
    bit   done;
    exp_t e;
    n = 0;
    done = 0;
    a_d = av; b_d = bv; cond_d = cv; tag_d = tg; fcc_idx_d = tg[2:0]; in_valid_d = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready_d) begin
        e.y = ey; e.inv = ei; e.fcc = tg[2:0]; e.tag = tg;
        q_d.push_back(e);
        done = 1;
      end else begin
        n++;
        if (n > 50) begin
          check("dp in_ready timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid_d = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_s.size() != 0 || q_d.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check(name, 64'(q_s.size() + q_d.size()), 64'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset y", {63'd0, y}, 64'd0);
    check("reset invalid", {63'd0, invalid}, 64'd0);
    check("reset out_fcc_idx", {61'd0, out_fcc_idx}, 64'd0);
    check("reset out_tag", {58'd0, out_tag}, 64'd0);
    check("reset sticky", {63'd0, sticky_invalid}, 64'd0);
    check("reset dp out_valid", {63'd0, out_valid_d}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready after reset", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // First vector alone to pin the latency.
    issue_s(VA[0], VB[0], VC[0], 6'd0, VY[0], VI[0], 1);
    repeat (DS - 1) begin
      @(negedge clk);
      check("sp latency early out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("sp latency out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;

    for (int i = 1; i < NV; i++) begin
      issue_s(VA[i], VB[i], VC[i], TAG_W'(i), VY[i], VI[i], 1);
    end
    drain("sp directed drain");
    check("sticky after invalid", {63'd0, sticky_invalid}, 64'd1);

    // Six back-to-back ops with a three-cycle output stall.
    fork
      begin
        for (int t = 0; t < 6; t++) begin
          if (t % 2 == 0) issue_s(32'h3f800000, 32'h40000000, 4'd4, TAG_W'(t), 1'b1, 1'b0, 1);
          else            issue_s(32'h40000000, 32'h3f800000, 4'd4, TAG_W'(t), 1'b0, 1'b0, 1);
        end
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 100) check("bp first result timeout", 64'd0, 64'd1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp in_ready during hold", {63'd0, in_ready}, 64'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp drain");

    // Three ops in flight, a fourth presented together with flush.
    for (int t = 0; t < 3; t++) begin
      issue_s(32'h7fc00000, 32'h0, 4'd1, TAG_W'(10 + t), 1'b1, 1'b1, 0);
    end
    a = 32'h7fc00000; b = 32'h0; cond = 4'd1; tag = 6'd13; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    begin
      bit seen;
      seen = 0;
      repeat (DS + 2) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      check("flush suppresses output", {63'd0, seen}, 64'd0);
    end
    check("sticky kept across flush", {63'd0, sticky_invalid}, 64'd1);
    @(posedge clk); #1;
    issue_s(32'h3f800000, 32'h3f800000, 4'd6, 6'd20, 1'b1, 1'b0, 1);
    repeat (DS - 1) begin
      @(negedge clk);
      check("post-flush early out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("post-flush out_valid", {63'd0, out_valid}, 64'd1);
    drain("post-flush drain");
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    check("sticky cleared", {63'd0, sticky_invalid}, 64'd0);
    @(posedge clk); #1;

    // Double precision, D=2.
    issue_d(64'h3ff0000000000000, 64'h0000000000000001, 4'd6, 6'd30, 1'b0, 1'b0);
    @(negedge clk);
    check("dp latency early out_valid", {63'd0, out_valid_d}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("dp latency out_valid", {63'd0, out_valid_d}, 64'd1);
    @(posedge clk); #1;
    issue_d(64'h0000000000000001, 64'h3ff0000000000000, 4'd6, 6'd31, 1'b1, 1'b0);
    issue_d(64'h8000000000000000, 64'h0000000000000000, 4'd2, 6'd32, 1'b1, 1'b0);
    issue_d(64'h7ff4000000000000, 64'h0000000000000000, 4'd2, 6'd33, 1'b0, 1'b0);
    issue_d(64'h7ff8000000000000, 64'h0000000000000000, 4'd0, 6'd34, 1'b0, 1'b1);
    drain("dp drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
    $fatal(1);
  end

endmodule

// File: doc/fp_cond_compare.md
# fp_cond_compare

Pipelined, parametrised floating-point condition compare for the FPU issue path. Evaluates the full 16-predicate c.cond.fmt family on single or double operands: ordered/unordered, equal, less-than and signalling variants. Returns a one-bit result, a per-op invalid-operation flag and a sticky invalid cause bit, all tagged with destination FCC index and ROB tag. It has a valid/ready handshake, backpressure and flush, so it can sit behind a shared FP issue port rather than in a fixed-latency slot.

## Interface
- W, 32: operand width; 32 or 64 only (F=23/52, E=8/11).
- D, 4: pipeline depth in stages, D ≥ 1.
- TAG_W, 6: ROB tag width.
- NAN2008, 0: 0 = legacy MIPS NaN encoding (fraction MSB=1 is signalling); 1 = IEEE-2008 (fraction MSB=0 is signalling).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  kill all in-flight ops.
- in_valid  in  1  op presented.
- in_ready  out  1  stage 0 can accept.
- a, b  in  W  operands.
- cond  in  4  predicate: bit0 U (unordered), bit1 E (equal), bit2 L (less), bit3 S (signalling).
- fcc_idx  in  3  destination condition-code bit.
- tag  in  TAG_W  ROB tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- y  out  1  predicate result.
- invalid  out  1  invalid-op for this result.
- out_fcc_idx  out  3  carried fcc_idx.
- out_tag  out  TAG_W  carried tag.
- clr_sticky  in  1  clear sticky cause.
- sticky_invalid  out  1  OR of all retired invalid flags since last clear.

## Operation
- NaN: exponent all ones, fraction ≠ 0. SNaN per NAN2008. un = a_nan | b_nan.
- Zero: all bits except sign are 0. ±0 compare equal.
- eq = !un & (a==b | both zero).
- lt = !un & !eq & ordered magnitude compare:
  - Signs differ: the negative operand is less.
  - Both positive: {exp,frac} of a < {exp,frac} of b.
  - Both negative: comparison reversed.
  - Denormals and infinities fall out of the raw compare naturally.
- y = (cond[0]&un) | (cond[1]&eq) | (cond[2]&lt).
- invalid = un & (cond[3] | a_snan | b_snan).
- Compute y/invalid combinationally in stage 0. Stages 1..D-1 only carry {valid, y, invalid, fcc_idx, tag}.
- Advance rule: pipeline moves when advance = !out_valid | out_ready. All stages hold otherwise.
- in_ready = advance. Accept = in_valid & in_ready.
- flush: clear every stage valid bit the same cycle. An op presented with flush high is not accepted. Flush has priority over accept and advance. Payload registers may hold stale data.
- sticky_invalid:
  - Set on the cycle out_valid & out_ready & invalid.
  - clr_sticky clears it; simultaneous set and clear leaves it set.
  - Unaffected by flush.

## Timing
- Reset: all valid bits 0, out_valid 0, y 0, invalid 0, out_fcc_idx 0, out_tag 0, sticky_invalid 0. in_ready is 1 from the first cycle after reset.
- Latency: accepted in cycle t → out_valid in cycle t+D when out_ready is held high. D=1 means stage 0 is registered directly to the outputs.
- Throughput: one op per cycle under out_ready=1.
- Backpressure: with out_ready=0 and out_valid=1, in_ready falls combinationally. No op is lost, duplicated or reordered. Bubbles are not collapsed; holding is global.
- Reset mid-operation clears everything asynchronously. No partial results.

## Structure
- Shared header fp_compare.vh gets a fp_cond_t enum for the 16 predicates (F, UN, EQ, UEQ, OLT, ULT, OLE, ULE, SF, NGLE, SEQ, NGL, LT, NGE, LE, NGT = 0..15) and the cond bit-position constants.
- Reuse the existing fp_special_cases for nan/zero decode. Add SNaN detection locally.
- One natural sub-module: fp_cmp_pipe, the valid/payload shift register parametrised on D and payload width, owning advance/flush.

## Test plan
- W=32, D=4: a=3f800000, b=40000000, cond=OLT(4), out_ready=1 → 4 cycles later y=1, invalid=0. Swap operands → y=0.
- a=80000000, b=00000000, cond=EQ(2) → y=1. cond=OLT → y=0. Also a=c0000000, b=bf800000, OLT → y=1 (both-negative path).
- NAN2008=0: a=7fbfffff (quiet), b=3f800000. cond=ULT(5) → y=1, invalid=0. cond=OLT → y=0. cond=LT(12) → invalid=1. a=7fc00000 (SNaN) with UN(1) → y=1, invalid=1.
- W=64, D=2: a=3ff0000000000000, b=0000000000000001 (denormal), cond=OLE(6) → y=0 after 2 cycles.
- Backpressure: stream 6 ops back-to-back, out_ready=0 from the cycle the first result appears for 3 cycles. Required: in_ready=0 during the hold, and results exit in order with tags 0..5 and none dropped.
- Flush with 3 ops in flight and a 4th presented → no out_valid for those 4. Next op after flush returns normally at latency D. sticky_invalid is unchanged by the flush and is cleared by clr_sticky.
